// File: rtl/keypad_pkg.sv
// Shared types and width helpers for the keypad debouncer.
// Optional auto-repeat is enabled with the KEYPAD_AUTOREPEAT_EN macro.
package keypad_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_CHK,
        PRESSED,
        REL_CHK
    } deb_state_t;

    localparam int MIN_WIDTH = 1;

    // Width of a counter that must hold the value 'cycles'.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? MIN_WIDTH : $clog2(cycles + 1);
    endfunction

    // Width of a channel index; never narrower than one bit.
    function automatic int idx_width(input int num_ch);
        return (num_ch < 2) ? MIN_WIDTH : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/keypad_debouncer_channel.sv
// One key line: synchroniser, stable-count debounce FSM and registered pulses.
// KEYPAD_AUTOREPEAT_EN adds a repeat timer that re-fires press_pulse while held.
module debounce_channel
    import keypad_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 32,
    parameter int REPEAT_PERIOD   = 8
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic row,
    output logic press_pulse,
    output logic release_pulse,
    output logic held
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    deb_state_t             state, state_d;
    logic [CW-1:0]          cnt, cnt_d;
    logic                   press_d, release_d, held_d;

    always_ff @(posedge clk) begin
        if (rst) sync <= '0;
        else     sync <= {sync[SYNC_STAGES-2:0], row};
    end

    assign s = sync[SYNC_STAGES-1];

    // The sample that leaves a settled state already counts as the first of the run.
    always_comb begin
        state_d   = state;
        cnt_d     = '0;
        press_d   = 1'b0;
        release_d = 1'b0;
        held_d    = held;
        if (!en) begin
            state_d = RELEASED;
            held_d  = 1'b0;
        end else begin
            case (state)
                RELEASED: if (s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = PRESSED;
                        press_d = 1'b1;
                        held_d  = 1'b1;
                    end else begin
                        state_d = PRESS_CHK;
                        cnt_d   = CW'(1);
                    end
                end
                PRESS_CHK: if (!s) begin
                    state_d = RELEASED;
                end else if (cnt == CNT_LAST) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                    held_d  = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
                PRESSED: if (!s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d   = RELEASED;
                        release_d = 1'b1;
                        held_d    = 1'b0;
                    end else begin
                        state_d = REL_CHK;
                        cnt_d   = CW'(1);
                    end
                end
                REL_CHK: if (s) begin
                    state_d = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_d   = RELEASED;
                    release_d = 1'b1;
                    held_d    = 1'b0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
                default: state_d = RELEASED;
            endcase
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int TW = cnt_width(REPEAT_DELAY);
    localparam logic [TW-1:0] T_LAST   = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] T_RELOAD = TW'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [TW-1:0] timer, timer_d;
    logic          repeat_fire;

    // Timer runs only while settled in PRESSED; a bounce through REL_CHK freezes it.
    always_comb begin
        timer_d     = timer;
        repeat_fire = 1'b0;
        if (!en || state_d == RELEASED) begin
            timer_d = '0;
        end else if (state == PRESSED && state_d == PRESSED) begin
            if (timer == T_LAST) begin
                repeat_fire = 1'b1;
                timer_d     = T_RELOAD;
            end else begin
                timer_d = timer + 1'b1;
            end
        end else if (state_d == PRESSED && state != REL_CHK) begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) timer <= '0;
        else     timer <= timer_d;
    end
`else
    logic repeat_fire;
    assign repeat_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RELEASED;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            held          <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            press_pulse   <= press_d | repeat_fire;
            release_pulse <= release_d;
            held          <= held_d;
        end
    end

endmodule

// File: rtl/keypad_debouncer.sv
// NUM_CH debounced key lines with press/release pulses and a lowest-index key code.
// Define KEYPAD_AUTOREPEAT_EN to enable auto-repeat press pulses while a key is held.
module keypad_debouncer
    import keypad_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 32,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [NUM_CH-1:0]             row,
    output logic [NUM_CH-1:0]             press_pulse,
    output logic [NUM_CH-1:0]             release_pulse,
    output logic [NUM_CH-1:0]             held,
    output logic                          key_valid,
    output logic [idx_width(NUM_CH)-1:0]  key_idx
);

    localparam int IW = idx_width(NUM_CH);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef KEYPAD_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .en            (en),
            .row           (row[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .held          (held[i])
        );
    end

    // Scan from the top so the lowest pressed index wins.
    always_comb begin
        key_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (press_pulse[i]) key_idx = IW'(i);
        end
    end

    assign key_valid = |press_pulse;

endmodule

// File: tb/tb_keypad_debouncer.sv
// Self-checking bench for keypad_debouncer with default parameters.
// Expected values come from a run-length debounce model and fixed vector tables.
module tb_keypad_debouncer;

    localparam int N    = 4;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int W    = 3 * N + 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b0;
    logic [N-1:0] row = '0;
    logic [N-1:0] press_pulse, release_pulse, held;
    logic         key_valid;
    logic [1:0]   key_idx;

    keypad_debouncer dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .row           (row),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .held          (held),
        .key_valid     (key_valid),
        .key_idx       (key_idx)
    );

    always #5 clk = ~clk;

    // Reference model: the synced sample seen at an edge is the raw row from SYNC edges
    // earlier; a level flips after DEB consecutive samples that disagree with it.
    logic [N-1:0] hist [SYNC];
    logic [N-1:0] m_lvl, m_press, m_rel;
    int           m_run [N];
    logic [W-1:0] exp_q [$];
    int           n_vec = 0;
    int           n_bad = 0;

    function automatic logic [1:0] lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return 2'(i);
        return 2'd0;
    endfunction

    function automatic logic [W-1:0] pack(input logic [N-1:0] p, r, h);
        return {p, r, h, |p, lowest(p)};
    endfunction

    function automatic void model_edge(input logic r, input logic e, input logic [N-1:0] rw);
        logic [N-1:0] s;
        m_press = '0;
        m_rel   = '0;
        if (r) begin
            for (int j = 0; j < SYNC; j++) hist[j] = '0;
            m_lvl = '0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
            return;
        end
        s = hist[SYNC-1];
        for (int j = SYNC - 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = rw;
        if (!e) begin
            m_lvl = '0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
            return;
        end
        for (int i = 0; i < N; i++) begin
            if (s[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_lvl[i] = ~m_lvl[i];
                    m_run[i] = 0;
                    if (m_lvl[i]) m_press[i] = 1'b1;
                    else          m_rel[i]   = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
        end
    endfunction

    task automatic check(input string name, input logic [W-1:0] exp);
        logic [W-1:0] got;
        got = {press_pulse, release_pulse, held, key_valid, key_idx};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t: got press=%b rel=%b held=%b valid=%b idx=%0d, want press=%b rel=%b held=%b valid=%b idx=%0d",
                     name, $time, got[W-1-:N], got[2*N+2-:N], got[N+2-:N], got[2], got[1:0],
                     exp[W-1-:N], exp[2*N+2-:N], exp[N+2-:N], exp[2], exp[1:0]);
        end
    endtask

    task automatic expect_int(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [N-1:0] rw);
        @(negedge clk);
        rst = r;
        en  = e;
        row = rw;
        model_edge(r, e, rw);
        exp_q.push_back(pack(m_press, m_rel, m_lvl));
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic r, input logic e, input logic [N-1:0] rw, input string name);
        drive(r, e, rw);
        check(name, exp_q.pop_front());
    endtask

    task automatic run(input int n, input logic r, input logic e, input logic [N-1:0] rw,
                       input string name, output int first_press,
                       output logic [N-1:0] press_or, output logic [N-1:0] rel_or);
        first_press = -1;
        press_or    = '0;
        rel_or      = '0;
        for (int i = 0; i < n; i++) begin
            step(r, e, rw, name);
            if (press_pulse != '0 && first_press < 0) first_press = i;
            press_or |= press_pulse;
            rel_or   |= release_pulse;
        end
    endtask

    typedef struct {
        logic         rst;
        logic         en;
        logic [N-1:0] row;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] held;
    } vec_t;

    vec_t tbl [23];

    initial begin
        int           fp;
        logic [N-1:0] por, ror, acc;
        logic [N-1:0] rw;
        logic         r, e;

        for (int j = 0; j < SYNC; j++) hist[j] = '0;
        m_lvl = '0;
        for (int i = 0; i < N; i++) m_run[i] = 0;

        // Reset, disabled with noise, then a clean press and release on ch0.
        for (int i = 0; i < 23; i++) begin
            tbl[i].rst   = (i < 3);
            tbl[i].en    = (i >= 8);
            tbl[i].row   = (i >= 3 && i < 6) ? N'($urandom_range(0, 15)) :
                           (i >= 8 && i < 16) ? 4'b0001 : 4'b0000;
            tbl[i].press = (i == 13) ? 4'b0001 : 4'b0000;
            tbl[i].rel   = (i == 21) ? 4'b0001 : 4'b0000;
            tbl[i].held  = (i >= 13 && i < 21) ? 4'b0001 : 4'b0000;
        end
        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].row);
            void'(exp_q.pop_front());
            check($sformatf("table[%0d]", i), pack(tbl[i].press, tbl[i].rel, tbl[i].held));
        end

        // Bounce on ch2 then a stable hold.
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            run(1, 1'b0, 1'b1, (i % 2 == 0) ? 4'b0100 : 4'b0000, "bounce_toggle", fp, por, ror);
            acc |= por;
        end
        run(8, 1'b0, 1'b1, 4'b0100, "bounce_hold", fp, por, ror);
        expect_int("bounce_no_early_press", int'(acc), 0);
        expect_int("bounce_press_latency", fp, 5);
        expect_int("bounce_press_mask", int'(por), 4);
        run(7, 1'b0, 1'b1, 4'b0000, "bounce_release", fp, por, ror);
        expect_int("bounce_release_mask", int'(ror), 4);

        // Three-cycle glitch on ch2.
        run(3, 1'b0, 1'b1, 4'b0100, "glitch_high", fp, por, ror);
        acc = por;
        run(8, 1'b0, 1'b1, 4'b0000, "glitch_low", fp, por, ror);
        expect_int("glitch_no_press", int'(acc | por), 0);

        // Simultaneous press on ch1 and ch3.
        run(5, 1'b0, 1'b1, 4'b1010, "simul_wait", fp, por, ror);
        step(1'b0, 1'b1, 4'b1010, "simul_commit");
        expect_int("simul_press", int'(press_pulse), 10);
        expect_int("simul_valid", int'(key_valid), 1);
        expect_int("simul_idx", int'(key_idx), 1);
        run(7, 1'b0, 1'b1, 4'b0000, "simul_release", fp, por, ror);

        // Disable mid-hold on ch3, then re-enable with the key still down.
        run(8, 1'b0, 1'b1, 4'b1000, "dis_hold", fp, por, ror);
        run(1, 1'b0, 1'b0, 4'b1000, "dis_off", fp, por, ror);
        expect_int("dis_held_cleared", int'(held), 0);
        expect_int("dis_no_release", int'(ror), 0);
        run(2, 1'b0, 1'b0, 4'b1000, "dis_off2", fp, por, ror);
        run(6, 1'b0, 1'b1, 4'b1000, "dis_reen", fp, por, ror);
        expect_int("reen_press_latency", fp, 3);
        expect_int("reen_press_mask", int'(por), 8);
        run(7, 1'b0, 1'b1, 4'b0000, "dis_release", fp, por, ror);

        // Reset during the press check on ch0.
        run(2, 1'b0, 1'b1, 4'b0001, "rst_rise", fp, por, ror);
        run(1, 1'b1, 1'b1, 4'b0001, "rst_hit", fp, por, ror);
        acc = por | held | release_pulse;
        run(6, 1'b0, 1'b1, 4'b0000, "rst_after", fp, por, ror);
        expect_int("rst_mid_outputs_zero", int'(acc), 0);
        expect_int("rst_mid_no_press", int'(por), 0);

        // Random stimulus against the model.
        rw = '0;
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(0, 5) == 0) rw[i] = ~rw[i];
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 59) != 0);
            step(r, e, rw, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/keypad_debouncer.md
Name: keypad_debouncer

Overview:
Parametrised successor to the 4-row keypad edge detector. Synchronises NUM_CH asynchronous keypad row lines and debounces each one with a per-channel stable-count state machine. Emits one-cycle press and release pulses, a debounced held level, and a lowest-index key code. Sits between the keypad pins and the elevator request logic.

Parameters:
- NUM_CH, 4: number of row/button channels, 1..16.
- SYNC_STAGES, 2: synchroniser flops per channel, at least 2.
- DEBOUNCE_CYCLES, 4: consecutive identical synced samples required to commit a state change, at least 1.
- REPEAT_DELAY, 32: cycles held before the first auto-repeat. Used only with the optional feature.
- REPEAT_PERIOD, 8: cycles between auto-repeats. Used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- en  in  1  enable; low forces idle.
- row  in  NUM_CH  raw asynchronous key lines, high = pressed.
- press_pulse  out  NUM_CH  one-cycle pulse per debounced press.
- release_pulse  out  NUM_CH  one-cycle pulse per debounced release.
- held  out  NUM_CH  debounced pressed level.
- key_valid  out  1  OR of press_pulse.
- key_idx  out  $clog2(NUM_CH) (minimum 1)  index of the lowest set press_pulse bit; 0 when key_valid=0.

Behaviour:
- All outputs are registered except key_valid and key_idx, which are combinational from the press_pulse register.
- Reset (rst=1 at a posedge):
  - Sync flops, counters, press_pulse, release_pulse and held clear to 0.
  - Every FSM goes to RELEASED.
  - Reset takes priority over en and over any in-flight check.
- Synchroniser: per-channel chain of SYNC_STAGES flops. It runs whenever rst=0, regardless of en. s[i] denotes the last stage.
- Per-channel FSM states: RELEASED, PRESS_CHK, PRESSED, REL_CHK. Each channel has a counter cnt of width $clog2(DEBOUNCE_CYCLES+1).
  - RELEASED: s=1 moves to PRESS_CHK with cnt=1. If DEBOUNCE_CYCLES=1, it commits directly to PRESSED.
  - PRESS_CHK: s=1 increments cnt. When cnt reaches DEBOUNCE_CYCLES, go to PRESSED, set press_pulse, set held, clear cnt. s=0 returns to RELEASED with cnt=0.
  - PRESSED: s=0 moves to REL_CHK (mirror of PRESS_CHK).
  - REL_CHK: committing goes to RELEASED, sets release_pulse and clears held. s=1 returns to PRESSED.
- Pulses last exactly one cycle. A press pulse occurs only on a RELEASED→PRESSED commit, never twice per hold.
- Latency: let k be the first posedge sampling row[i]=1, with row held stable. press_pulse[i] is high in the cycle after posedge k+SYNC_STAGES+DEBOUNCE_CYCLES-1. With defaults this is edge k+5. Release latency is identical.
- en=0 at a posedge:
  - FSMs go to RELEASED and counters clear.
  - press_pulse, release_pulse and held are 0 from the next cycle.
  - No release_pulse is generated on disable.
- en rising with a key still pressed: the channel starts from RELEASED and produces a press_pulse after DEBOUNCE_CYCLES synced-high samples.
- Simultaneous commits on several channels pulse in the same cycle. key_idx reports the lowest index.
- A glitch shorter than DEBOUNCE_CYCLES synced cycles produces no pulse and no change in held.
- Counters never wrap, because commit or abort always clears them.

Optional Feature:
Macro KEYPAD_AUTOREPEAT_EN.
- Defined:
  - Each channel has a repeat timer that is cleared on entry to PRESSED.
  - Extra press_pulse events are raised after REPEAT_DELAY cycles in PRESSED, then every REPEAT_PERIOD cycles.
  - The timer holds while the channel is in REL_CHK and clears on RELEASED or en=0.
- Undefined: no repeat logic; exactly one press_pulse per hold.

Decomposition:
- Package keypad_pkg:
  - deb_state_t enum {RELEASED, PRESS_CHK, PRESSED, REL_CHK}.
  - Helper localparams for counter and index widths.
- Sub-module debounce_channel: one synchroniser, FSM and counter (plus repeat timer under the macro). It is instantiated NUM_CH times in a generate loop. The top adds the priority encoder.

Test Plan:
All cases use default parameters; changes are applied at negedge.
- Reset/enable: rst for 3 cycles, en=0, random row for 5 cycles → all outputs 0, key_valid=0.
- Clean press on ch0: en=1, row=0001 held → press_pulse=0001 for 1 cycle at edge k+5, held[0]=1 thereafter, key_idx=0. Drop row → release_pulse=0001 once at 5 edges after the drop, held=0.
- Bounce on ch2: row[2] pattern 1,0,1,0 then 1 held → no pulse during the toggling; one press_pulse=0100 exactly 5 edges after the final rise. A 3-cycle high glitch → no pulse.
- Simultaneous: row=1010 in one cycle → press_pulse=1010, key_valid=1, key_idx=1.
- Disable mid-hold: ch3 held, en=0 → held=0 next cycle with no release_pulse. Re-enable with key held → new press_pulse=1000 after 4 cycles.
- Reset mid-PRESS_CHK: rst asserted 2 cycles after the rise → no press_pulse, all outputs 0. With KEYPAD_AUTOREPEAT_EN, holding ch1 for 60 cycles → pulses at commit, commit+32, commit+40, commit+48, commit+56.
